// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage operand delay line with a runtime-selected tap.
//
// Each stage carries a valid tag alongside its data. A saturating fill counter
// tracks how many shifts have happened since the last reset or flush, so the
// selected tap can report whether it holds freshly shifted data (primed).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (stages <= RSTVAL, tags/fill cleared)
//   CE         shift enable; when low every stage holds
//   flush      clears valid tags and fill; data stages hold, no shift
//   data       data into stage 0
//   valid_in   valid tag accompanying data
//   tap        selected latency in cycles, 0 = combinational bypass, clamps at DEPTH
//   out        data at the selected tap
//   valid_out  valid tag at the selected tap (not qualified by primed)
//   primed     selected tap holds data shifted in since the last reset or flush
module reg_pipe #(
    parameter int unsigned    N      = 18,
    parameter int unsigned    DEPTH  = 4,
    parameter int unsigned    TAPW   = $clog2(DEPTH + 1),
    parameter logic [N-1:0]   RSTVAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            CE,
    input  logic            flush,
    input  logic [N-1:0]    data,
    input  logic            valid_in,
    input  logic [TAPW-1:0] tap,
    output logic [N-1:0]    out,
    output logic            valid_out,
    output logic            primed
);

    logic [N-1:0]     stage_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [TAPW-1:0]  fill_q;
    logic [TAPW-1:0]  eff_tap;

    // Priority: rst, then flush, then CE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= RSTVAL;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else if (flush) begin
            vld_q  <= '0;
            fill_q <= '0;
        end else if (CE) begin
            stage_q[0] <= data;
            vld_q[0]   <= valid_in;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_q[k] <= stage_q[k-1];
                vld_q[k]   <= vld_q[k-1];
            end
            if (fill_q != TAPW'(DEPTH)) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Taps above DEPTH behave as the deepest stage.
    always_comb begin
        eff_tap = tap;
        if (tap > TAPW'(DEPTH)) begin
            eff_tap = TAPW'(DEPTH);
        end
    end

    // Tap 0 is a pure bypass; otherwise a decoded mux avoids an index wider
    // than the stage array needs.
    always_comb begin
        out       = data;
        valid_out = valid_in;
        primed    = 1'b1;
        if (eff_tap != '0) begin
            primed = (fill_q >= eff_tap);
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (eff_tap == TAPW'(k + 1)) begin
                    out       = stage_q[k];
                    valid_out = vld_q[k];
                end
            end
        end
    end

endmodule
